adc_spi_master: RTL and testbench

3-wire SPI master serving the ADC configuration command interface. Accepts one 24-bit write or read frame per command and serialises it onto CSB/SCLK/SDIO. Returns the 8-bit read-back byte. Sits between the configuration sequencer and the ADC SPI pins; the sequencer only ever sees `busy` and `rd_data`.

---
 rtl/adc_spi_master.sv | 171 +++++++++++++++++
 tb/tb_adc_spi_master.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_master.sv
// 3-wire SPI master for the ADC configuration port: one 24-bit frame per command,
// MSB first, with an 8-bit read-back captured while SDIO is turned around.
module adc_spi_master #(
  parameter int MOSI_DATA_WIDTH = 24,
  parameter int MISO_DATA_WIDTH = 8,
  parameter int CLK_DIV         = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_spi_wr_cmd,
  input  logic                       i_spi_rd_cmd,
  input  logic [MOSI_DATA_WIDTH-1:0] i_spi_wr_data,
  output logic [MISO_DATA_WIDTH-1:0] o_spi_rd_data,
  output logic                       o_spi_busy,
  output logic                       o_spi_csb,
  output logic                       o_spi_sclk,
  output logic                       o_spi_sdio_o,
  output logic                       o_spi_sdio_oe,
  input  logic                       i_spi_sdio_i
);

  localparam logic [7:0] DIV_MAX     = 8'(CLK_DIV - 1);
  localparam logic [4:0] BIT_MSB     = 5'(MOSI_DATA_WIDTH - 1);
  localparam logic [4:0] RD_LAST_BIT = 5'(MISO_DATA_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP} state_t;

  state_t                     state_q, state_d;
  logic                       busy_q;
  logic [7:0]                 div_q, div_d;
  logic [4:0]                 bit_q, bit_d;
  logic                       phase_q, phase_d;
  logic                       rd_q, rd_d;
  logic [MOSI_DATA_WIDTH-1:0] frame_q, frame_d;
  logic [MISO_DATA_WIDTH-1:0] rx_q, rx_d;
  logic [MISO_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                       div_end;

  assign div_end = (div_q == DIV_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      div_q     <= '0;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      rd_q      <= 1'b0;
      frame_q   <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != S_IDLE);
      div_q     <= div_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      rd_q      <= rd_d;
      frame_q   <= frame_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    rd_d      = rd_q;
    frame_d   = frame_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    case (state_q)
      S_IDLE: begin
        div_d   = '0;
        bit_d   = '0;
        phase_d = 1'b0;
        if (i_spi_wr_cmd || i_spi_rd_cmd) begin
          state_d = S_LEAD;
          rd_d    = i_spi_rd_cmd;
          frame_d = i_spi_wr_data;
          // A read wins over a simultaneous write; clearing the byte stops stale compares.
          if (i_spi_rd_cmd) begin
            frame_d[MOSI_DATA_WIDTH-1] = 1'b1;
            rd_data_d                  = '0;
          end
        end
      end
      S_LEAD: begin
        if (div_end) begin
          state_d = S_SHIFT;
          div_d   = '0;
          bit_d   = BIT_MSB;
          phase_d = 1'b0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_SHIFT: begin
        if (phase_q && (div_q == 8'd0)) begin
          rx_d = {rx_q[MISO_DATA_WIDTH-2:0], i_spi_sdio_i};
        end
        if (div_end) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (bit_q == 5'd0) begin
            state_d = S_TRAIL;
            if (rd_q) begin
              rd_data_d = rx_q;
            end
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q - 5'd1;
            frame_d = {frame_q[MOSI_DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_TRAIL: begin
        if (div_end) begin
          state_d = S_GAP;
          div_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_GAP: begin
        if (div_end) begin
          state_d = S_IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_spi_csb     = 1'b1;
    o_spi_sclk    = 1'b0;
    o_spi_sdio_o  = 1'b0;
    o_spi_sdio_oe = 1'b0;
    case (state_q)
      S_LEAD: begin
        o_spi_csb     = 1'b0;
        o_spi_sdio_o  = frame_q[MOSI_DATA_WIDTH-1];
        o_spi_sdio_oe = 1'b1;
      end
      S_SHIFT: begin
        o_spi_csb     = 1'b0;
        o_spi_sclk    = phase_q;
        o_spi_sdio_o  = frame_q[MOSI_DATA_WIDTH-1];
        // Bus turns around for the data byte of a read.
        o_spi_sdio_oe = !(rd_q && (bit_q <= RD_LAST_BIT));
      end
      S_TRAIL: begin
        o_spi_csb     = 1'b0;
        o_spi_sdio_oe = !rd_q;
      end
      default: ;
    endcase
  end

  assign o_spi_busy    = busy_q;
  assign o_spi_rd_data = rd_data_q;

endmodule

// File: tb/tb_adc_spi_master.sv
// Randomized self-checking bench for adc_spi_master at CLK_DIV 4 and 2.
module tb_adc_spi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_wr, cmd_rd;
  logic [23:0] wr_data;
  logic        sdio_in;
  int          sel;

  logic       wr4, rd4, wr2, rd2;
  logic [7:0] rd_data4, rd_data2;
  logic       busy4, csb4, sclk4, sdo4, oe4;
  logic       busy2, csb2, sclk2, sdo2, oe2;

  logic [7:0] obs_rd_data;
  logic       obs_busy, obs_csb, obs_sclk, obs_sdo, obs_oe;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] model_rd [2];

  always #5 clk = ~clk;

  assign wr4 = cmd_wr && (sel == 0);
  assign rd4 = cmd_rd && (sel == 0);
  assign wr2 = cmd_wr && (sel == 1);
  assign rd2 = cmd_rd && (sel == 1);

  assign obs_rd_data = (sel == 1) ? rd_data2 : rd_data4;
  assign obs_busy    = (sel == 1) ? busy2 : busy4;
  assign obs_csb     = (sel == 1) ? csb2 : csb4;
  assign obs_sclk    = (sel == 1) ? sclk2 : sclk4;
  assign obs_sdo     = (sel == 1) ? sdo2 : sdo4;
  assign obs_oe      = (sel == 1) ? oe2 : oe4;

  adc_spi_master #(.MOSI_DATA_WIDTH(24), .MISO_DATA_WIDTH(8), .CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_spi_wr_cmd(wr4), .i_spi_rd_cmd(rd4),
    .i_spi_wr_data(wr_data), .o_spi_rd_data(rd_data4), .o_spi_busy(busy4),
    .o_spi_csb(csb4), .o_spi_sclk(sclk4), .o_spi_sdio_o(sdo4),
    .o_spi_sdio_oe(oe4), .i_spi_sdio_i(sdio_in)
  );

  adc_spi_master #(.MOSI_DATA_WIDTH(24), .MISO_DATA_WIDTH(8), .CLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_spi_wr_cmd(wr2), .i_spi_rd_cmd(rd2),
    .i_spi_wr_data(wr_data), .o_spi_rd_data(rd_data2), .o_spi_busy(busy2),
    .o_spi_csb(csb2), .o_spi_sclk(sclk2), .o_spi_sdio_o(sdo2),
    .o_spi_sdio_oe(oe2), .i_spi_sdio_i(sdio_in)
  );

  task automatic check_eq(input string tag, input int got, input int expd);
    n_checks++;
    if (got !== expd) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expd);
    end
  endtask

  // Runs one frame on the selected instance and checks it against the frame rules.
  task automatic do_frame(input bit wr, input bit rd, input logic [23:0] data,
                          input logic [7:0] sbyte);
    int          div, rises, falls, busy_cnt, first_rise, second_rise;
    int          oe_low_first, oe_low_cnt, csb_high_busy;
    bit          prev_sclk, done;
    logic [23:0] exp_frame, cap;
    div = (sel == 1) ? 2 : 4;
    exp_frame = data;
    if (rd) exp_frame[23] = 1'b1;
    rises = 0; falls = 0; busy_cnt = 0; first_rise = -1; second_rise = -1;
    oe_low_first = -1; oe_low_cnt = 0; csb_high_busy = 0;
    prev_sclk = 1'b0; done = 1'b0; cap = '0;
    @(negedge clk);
    cmd_wr = wr; cmd_rd = rd; wr_data = data; sdio_in = 1'b0;
    for (int n = 1; n <= 60 * div && !done; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check_eq("busy_c1", int'(obs_busy), 1);
        check_eq("csb_c1", int'(obs_csb), 0);
        if (rd) check_eq("rd_clear_c1", int'(obs_rd_data), 0);
      end
      if (n == 2) begin
        cmd_wr = 1'b0; cmd_rd = 1'b0;
      end
      if (obs_busy) busy_cnt++;
      else done = 1'b1;
      if (obs_sclk && !prev_sclk) begin
        rises++;
        cap = {cap[22:0], obs_sdo};
        if (first_rise < 0) first_rise = n;
        else if (second_rise < 0) second_rise = n;
      end
      if (!obs_sclk && prev_sclk) begin
        falls++;
        if (falls >= 16 && falls <= 23) sdio_in = sbyte[23 - falls];
        else sdio_in = 1'($urandom_range(0, 1));
      end
      prev_sclk = obs_sclk;
      if (!obs_csb && !obs_oe) begin
        oe_low_cnt++;
        if (oe_low_first < 0) oe_low_first = n;
      end
      if (obs_busy && obs_csb) csb_high_busy++;
      if (rd && n == 1 + 50 * div) check_eq("rd_data_before_idle", int'(obs_rd_data), int'(sbyte));
    end
    cmd_wr = 1'b0; cmd_rd = 1'b0;
    check_eq("busy_fell", int'(done), 1);
    check_eq("busy_len", busy_cnt, 51 * div);
    check_eq("sclk_pulses", rises, 24);
    check_eq("first_rise", first_rise, 1 + 2 * div);
    check_eq("sclk_period", second_rise - first_rise, 2 * div);
    check_eq("csb_gap", csb_high_busy, div);
    if (rd) begin
      check_eq("tx_instr", int'(cap[23:8]), int'(exp_frame[23:8]));
      check_eq("oe_drop_cycle", oe_low_first, 1 + 33 * div);
      check_eq("oe_low_len", oe_low_cnt, 17 * div);
      model_rd[sel] = sbyte;
    end else begin
      check_eq("tx_frame", int'(cap), int'(exp_frame));
      check_eq("oe_never_low", oe_low_cnt, 0);
    end
    check_eq("rd_data_final", int'(obs_rd_data), int'(model_rd[sel]));
    $display("frame div=%0d wr=%0d rd=%0d data=%06h sent=%06h rd_data=%02h busy=%0d",
             div, wr, rd, data, cap, obs_rd_data, busy_cnt);
  endtask

  // Holds a write command for many cycles and counts the frames that result.
  task automatic hold_test(input int hold);
    int div, falls, busy_rises, last_rise, gap, exp_frames;
    bit prev_csb, prev_busy;
    div = (sel == 1) ? 2 : 4;
    exp_frames = (hold - 1) / (51 * div + 1) + 1;
    falls = 0; busy_rises = 0; last_rise = -1; gap = -1;
    prev_csb = 1'b1; prev_busy = 1'b0;
    @(negedge clk);
    cmd_wr = 1'b1; cmd_rd = 1'b0; wr_data = 24'($urandom);
    for (int n = 1; n <= hold + 60 * div; n++) begin
      @(negedge clk);
      if (n == hold) cmd_wr = 1'b0;
      if (!obs_csb && prev_csb) begin
        falls++;
        if (falls == 2) gap = n - last_rise;
      end
      if (obs_csb && !prev_csb) last_rise = n;
      if (obs_busy && !prev_busy) busy_rises++;
      prev_csb = obs_csb;
      prev_busy = obs_busy;
    end
    check_eq("held_frames", falls, exp_frames);
    check_eq("held_busy_rises", busy_rises, exp_frames);
    check_eq("held_csb_gap_min", int'(gap >= div), 1);
    check_eq("held_csb_gap", gap, div + 1);
    check_eq("held_idle_end", int'(obs_busy), 0);
    check_eq("held_rd_data", int'(obs_rd_data), int'(model_rd[sel]));
    $display("hold div=%0d cycles=%0d frames=%0d csb_gap=%0d", div, hold, falls, gap);
  endtask

  initial begin
    rst_n = 1'b0; cmd_wr = 1'b0; cmd_rd = 1'b0; wr_data = '0; sdio_in = 1'b0; sel = 0;
    model_rd[0] = 8'h00; model_rd[1] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", int'(busy4), 0);
    check_eq("rst_csb", int'(csb4), 1);
    check_eq("rst_sclk", int'(sclk4), 0);
    check_eq("rst_oe", int'(oe4), 0);
    check_eq("rst_sdo", int'(sdo4), 0);
    check_eq("rst_rd_data", int'(rd_data4), 0);
    check_eq("rst_csb_div2", int'(csb2), 1);
    rst_n = 1'b1;

    do_frame(1'b1, 1'b0, 24'h000F08, 8'h55);
    do_frame(1'b0, 1'b1, 24'h008001, 8'h6A);
    do_frame(1'b1, 1'b0, 24'($urandom), 8'h00);
    hold_test(300);
    do_frame(1'b1, 1'b1, 24'h00002A, 8'h03);

    // Abort a write at bit 12, then confirm a clean restart.
    do_frame(1'b0, 1'b1, 24'($urandom), 8'hC3);
    @(negedge clk);
    cmd_wr = 1'b1; wr_data = 24'h5A5A5A;
    for (int n = 1; n <= 1 + 23 * 4; n++) begin
      @(negedge clk);
      if (n == 2) cmd_wr = 1'b0;
    end
    check_eq("midframe_busy", int'(obs_busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_csb", int'(obs_csb), 1);
    check_eq("abort_sclk", int'(obs_sclk), 0);
    check_eq("abort_oe", int'(obs_oe), 0);
    check_eq("abort_busy", int'(obs_busy), 0);
    check_eq("abort_rd_data", int'(obs_rd_data), 0);
    rst_n = 1'b1;
    model_rd[0] = 8'h00; model_rd[1] = 8'h00;
    repeat (10) @(negedge clk);
    check_eq("no_resume_csb", int'(obs_csb), 1);
    $display("reset abort at bit 12 done");
    do_frame(1'b1, 1'b0, 24'h5A5A5A, 8'h00);

    for (int i = 0; i < 6; i++) begin
      int k;
      k = $urandom_range(0, 2);
      do_frame(k != 1, k != 0, 24'($urandom), 8'($urandom));
    end

    sel = 1;
    do_frame(1'b0, 1'b1, 24'($urandom), 8'hA5);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = $urandom_range(0, 2);
      do_frame(k != 1, k != 0, 24'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
